// File: rtl/rv_mem_pkg.sv
// Shared data-memory definitions: requester ownership tag, memory geometry and
// the byte-address range check used by the data-memory arbiter.
package rv_mem_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_W;

  // A byte address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters (core LSU, debug/loader), the data
// memory and the arbiter; slave is the arbiter's view, master the environment's.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [31:0]       core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata, core_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata, core_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/arb_wait_counter.sv
// Saturating wait counter: counts cycles a requester is refused, clears when it
// is served, and flags saturation so the arbiter can force it through.
module arb_wait_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == CNT_MAX);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core LSU and the debug port.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin conflicts instead of core priority.
module dmem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);
  logic              core_gnt, dbg_gnt, any_gnt, dbg_pick;
  owner_e            win;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_rng;

  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_rd_q, rsp_rd_d;
  logic              rsp_err_q, rsp_err_d;
  owner_e            rsp_own_q, rsp_own_d;
  logic [DATA_W-1:0] rsp_data;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (any_gnt) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= OWN_CORE;
    end else begin
      last_q <= last_d;
    end
  end

  assign dbg_pick = (last_q == OWN_CORE);
`else
  logic wait_sat;

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (bus.dbg_req && !dbg_gnt),
    .clr  (dbg_gnt),
    .sat  (wait_sat)
  );

  assign dbg_pick = wait_sat;
`endif

  // Lock or an uncontested debug request always wins; dbg_pick settles conflicts.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (reset) begin
      if (bus.dbg_req && (bus.dbg_lock || !bus.core_req || dbg_pick)) begin
        dbg_gnt = 1'b1;
      end else if (bus.core_req) begin
        core_gnt = 1'b1;
      end
    end
  end

  assign any_gnt = core_gnt || dbg_gnt;
  assign win     = dbg_gnt ? OWN_DBG : OWN_CORE;

  always_comb begin
    sel_we    = bus.core_we;
    sel_addr  = bus.core_addr;
    sel_wdata = bus.core_wdata;
    if (win == OWN_DBG) begin
      sel_we    = bus.dbg_we;
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
    end
    in_rng = addr_in_range(sel_addr, ADDR_W);
  end

  assign bus.core_gnt  = core_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.mem_en    = any_gnt && in_rng;
  assign bus.mem_we    = any_gnt && in_rng && sel_we;
  assign bus.mem_addr  = any_gnt ? sel_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = any_gnt ? sel_wdata : '0;

  // Response tag captured with the grant, consumed one cycle later.
  always_comb begin
    rsp_vld_d = any_gnt;
    rsp_own_d = win;
    rsp_rd_d  = any_gnt && in_rng && !sel_we;
    rsp_err_d = any_gnt && !in_rng;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_q <= 1'b0;
      rsp_own_q <= OWN_CORE;
      rsp_rd_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_own_q <= rsp_own_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    rsp_data        = rsp_rd_q ? bus.mem_rdata : '0;
    bus.core_rvalid = rsp_vld_q && (rsp_own_q == OWN_CORE);
    bus.dbg_rvalid  = rsp_vld_q && (rsp_own_q == OWN_DBG);
    bus.core_rdata  = bus.core_rvalid ? rsp_data : '0;
    bus.dbg_rdata   = bus.dbg_rvalid ? rsp_data : '0;
    bus.core_err    = bus.core_rvalid && rsp_err_q;
    bus.dbg_err     = bus.dbg_rvalid && rsp_err_q;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a behavioural arbitration/memory model
// predicts grants and responses; a negedge monitor pops and compares responses.
module tb_dmem_port_arbiter;
  import rv_mem_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH    = 1 << ADDR_W;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam logic [31:0] FIRST_DBG = 32'd0;
`else
  localparam logic [31:0] FIRST_DBG = 32'(MAX_WAIT);
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Data memory seen by the arbiter
  logic [31:0] mem [DEPTH] = '{default: '0};
  logic [31:0] mem_rdata_q = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      mem_rdata_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[2][$];
  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  int          wcnt = 0;
  owner_e      last = OWN_CORE;
  logic        exp_cg = 1'b0, exp_dg = 1'b0;
  logic        dut_cg = 1'b0, dut_dg = 1'b0;
  int          checks = 0, passed = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mon_port(input int p, input logic rv, input logic [31:0] rd, input logic er);
    rsp_t  e;
    string nm;
    nm = (p == 0) ? "core" : "dbg";
    if (rv) begin
      if (exp_q[p].size() == 0) begin
        check({nm, " unexpected rvalid"}, 32'(rv), 32'd0);
      end else begin
        e = exp_q[p].pop_front();
        check({nm, " rdata"}, rd, e.rdata);
        check({nm, " err"}, 32'(er), 32'(e.err));
        check({nm, " latency"}, 32'(cyc), 32'(e.due));
      end
    end else if (exp_q[p].size() != 0 && exp_q[p][0].due <= cyc) begin
      e = exp_q[p].pop_front();
      check({nm, " missing rvalid"}, 32'(rv), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, bus.core_rvalid, bus.core_rdata, bus.core_err);
    mon_port(1, bus.dbg_rvalid, bus.dbg_rdata, bus.dbg_err);
  end

  // Reference: decides the winner from the request rules, then predicts memory and response.
  task automatic model_cycle();
    logic        cr, dr, cg, dg, pick_dbg, we, inr;
    logic [31:0] addr, wd;
    int          idx;
    rsp_t        e;
    cr = bus.core_req;
    dr = bus.dbg_req;
    dut_cg = bus.core_gnt;
    dut_dg = bus.dbg_gnt;
    if (!reset) begin
      check("reset gnt/mem_en", {29'd0, bus.core_gnt, bus.dbg_gnt, bus.mem_en}, 32'd0);
      check("reset rvalid/err", {28'd0, bus.core_rvalid, bus.dbg_rvalid, bus.core_err, bus.dbg_err}, 32'd0);
      check("reset core_rdata", bus.core_rdata, 32'd0);
      check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
      wcnt = 0;
      last = OWN_CORE;
      exp_cg = 1'b0;
      exp_dg = 1'b0;
      return;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    pick_dbg = (last == OWN_CORE);
`else
    pick_dbg = (wcnt == MAX_WAIT);
`endif
    cg = 1'b0;
    dg = 1'b0;
    if (dr && bus.dbg_lock) dg = 1'b1;
    else if (cr && dr) begin
      if (pick_dbg) dg = 1'b1;
      else cg = 1'b1;
    end else begin
      cg = cr;
      dg = dr;
    end
    check("core_gnt", 32'(bus.core_gnt), 32'(cg));
    check("dbg_gnt", 32'(bus.dbg_gnt), 32'(dg));
    if (cg || dg) begin
      we   = cg ? bus.core_we : bus.dbg_we;
      addr = cg ? bus.core_addr : bus.dbg_addr;
      wd   = cg ? bus.core_wdata : bus.dbg_wdata;
      inr  = addr < 32'(DEPTH * 4);
      idx  = int'((addr >> 2) % DEPTH);
      check("mem_en", 32'(bus.mem_en), 32'(inr));
      if (inr) begin
        check("mem_we", 32'(bus.mem_we), 32'(we));
        check("mem_addr", 32'(bus.mem_addr), 32'(idx));
        if (we) check("mem_wdata", bus.mem_wdata, wd);
      end
      e.due   = cyc + 1;
      e.rdata = (we || !inr) ? 32'd0 : ref_mem[idx];
      e.err   = !inr;
      exp_q[cg ? 0 : 1].push_back(e);
      if (we && inr) ref_mem[idx] = wd;
    end else begin
      check("mem_en idle", 32'(bus.mem_en), 32'd0);
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (cg || dg) last = dg ? OWN_DBG : OWN_CORE;
`else
    if (dg) wcnt = 0;
    else if (dr) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
`endif
    exp_cg = cg;
    exp_dg = dg;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    if (p == 0) begin
      bus.core_req = r; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
    end else begin
      bus.dbg_req = r; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    end
  endtask

  task automatic req_op(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    set_req(p, 1'b1, we, a, d);
    for (int i = 0; i < 4 * MAX_WAIT && !got; i++) begin
      step();
      got = (p == 0) ? exp_cg : exp_dg;
    end
    if (!got) check("op grant timeout", 32'((p == 0) ? dut_cg : dut_dg), 32'd1);
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 15))
      0:       a = $urandom | 32'h0000_1000;
      1, 2, 3: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      default: a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
    endcase
    return a;
  endfunction

  initial begin
    int   first;
    logic gp, rq;
    bus.dbg_lock = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h4, 32'h55);
    set_req(1, 1'b1, 1'b1, 32'h8, 32'h66);
    repeat (3) step();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Continuous contention from a fresh starvation count
    set_req(0, 1'b1, 1'b0, 32'h10, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'd0);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (first < 0 && dut_dg) first = i;
    end
    check("first dbg win under contention", 32'(first), FIRST_DBG);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();

    req_op(0, 1'b1, 32'h8, 32'h140);
    req_op(0, 1'b0, 32'h8, 32'd0);
    req_op(0, 1'b1, 32'h1000, 32'hFFFF);
    req_op(0, 1'b0, 32'h0, 32'd0);
    step();

    // Locked debug burst while the core keeps requesting
    set_req(0, 1'b1, 1'b0, 32'h40, 32'd0);
    bus.dbg_lock = 1'b1;
    for (int k = 0; k < 16; k++) req_op(1, 1'b1, 32'(k * 4), 32'(k));
    bus.dbg_lock = 1'b0;
    req_op(0, 1'b0, 32'h40, 32'd0);
    for (int k = 0; k < 16; k++) req_op(0, 1'b0, 32'(k * 4), 32'd0);

    // Reset while a read response is in flight
    req_op(0, 1'b0, 32'h8, 32'd0);
    reset = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) step();
    reset = 1'b1;
    req_op(0, 1'b0, 32'h8, 32'd0);
    step();

    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 2; p++) begin
        gp = (p == 0) ? exp_cg : exp_dg;
        rq = (p == 0) ? bus.core_req : bus.dbg_req;
        if (!rq || gp) begin
          if ($urandom_range(0, 9) < 7) set_req(p, 1'b1, 1'($urandom), rand_addr(), $urandom);
          else set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
        end else if ($urandom_range(0, 19) == 0) begin
          set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
      bus.dbg_lock = ($urandom_range(0, 7) == 0);
      step();
    end

    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.dbg_lock = 1'b0;
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
